output_mem: RTL and testbench

- Output-side pixel buffer for the rotate engine. It is the write-back counterpart of the AHB-read input buffer.
- The rotate core scatters up to 4 rotated pixel bytes per cycle into a byte-addressed tile memory.
- When the core signals the tile complete, a drain FSM reads the tile out as sequential 32-bit little-endian words toward the AHB master write data path, under a valid/ready handshake.

---
 rtl/output_mem.sv | 96 +++++++++
 tb/tb_output_mem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_mem.sv
// output_mem: byte-scatter tile buffer drained as little-endian 32-bit words over valid/ready
module output_mem #(
    parameter int DEPTH  = 192,
    parameter int ADDR_W = 8
) (
    input  logic              I_OMEM_HCLK,
    input  logic              I_OMEM_HRESET_N,
    input  logic              I_OMEM_WRITE,
    input  logic [3:0]        I_OMEM_BYTE_EN,
    input  logic [ADDR_W-1:0] I_OMEM_PIXEL_IN_ADDR0,
    input  logic [ADDR_W-1:0] I_OMEM_PIXEL_IN_ADDR1,
    input  logic [ADDR_W-1:0] I_OMEM_PIXEL_IN_ADDR2,
    input  logic [ADDR_W-1:0] I_OMEM_PIXEL_IN_ADDR3,
    input  logic [31:0]       I_OMEM_PIXEL_WDATA,
    input  logic              I_OMEM_TILE_DONE,
    output logic              O_OMEM_READY,
    output logic [31:0]       O_OMEM_WDATA,
    output logic [5:0]        O_OMEM_WORD_ADDR,
    output logic              O_OMEM_WVALID,
    input  logic              I_OMEM_WREADY,
    output logic              O_OMEM_DONE,
    output logic              O_OMEM_ERR
);
    localparam int WORDS = DEPTH / 4;
    localparam logic [5:0] LAST = 6'(WORDS - 1);

    typedef enum logic [1:0] {S_FILL, S_DRAIN, S_DONE} state_t;

    state_t            state, state_nx;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] addr [4];
    logic [3:0]        lane_ok;
    logic [5:0]        k;
    logic [ADDR_W-1:0] base;
    logic [31:0]       word;
    logic              hs, bad, err;

    assign addr[0] = I_OMEM_PIXEL_IN_ADDR0;
    assign addr[1] = I_OMEM_PIXEL_IN_ADDR1;
    assign addr[2] = I_OMEM_PIXEL_IN_ADDR2;
    assign addr[3] = I_OMEM_PIXEL_IN_ADDR3;
    assign base    = ADDR_W'({k, 2'b00});

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane_ok[i]       = {1'b0, addr[i]} < (ADDR_W + 1)'(DEPTH);
        assign word[8*i +: 8]   = mem[base | ADDR_W'(i)];
    end

    assign hs  = (state == S_DRAIN) && I_OMEM_WREADY;
    assign bad = (state == S_FILL) ? I_OMEM_WRITE && |(I_OMEM_BYTE_EN & ~lane_ok)
                                   : I_OMEM_WRITE || I_OMEM_TILE_DONE;

    assign O_OMEM_WORD_ADDR = k;
    assign O_OMEM_ERR       = err;

    // next state and state-decoded outputs; word data only shown while valid
    always_comb begin
        state_nx      = state;
        O_OMEM_READY  = state == S_FILL;
        O_OMEM_WVALID = state == S_DRAIN;
        O_OMEM_DONE   = state == S_DONE;
        O_OMEM_WDATA  = (state == S_DRAIN) ? word : 32'h0;
        case (state)
            S_FILL:  state_nx = I_OMEM_TILE_DONE ? S_DRAIN : S_FILL;
            S_DRAIN: state_nx = (hs && k == LAST) ? S_DONE : S_DRAIN;
            default: state_nx = S_FILL;
        endcase
    end

    // state, drain word index and sticky error
    always_ff @(posedge I_OMEM_HCLK or negedge I_OMEM_HRESET_N) begin
        if (!I_OMEM_HRESET_N) begin
            state <= S_FILL;
            k     <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (hs)
                k <= (k == LAST) ? 6'd0 : k + 6'd1;
            if (bad)
                err <= 1'b1;
        end
    end

    // byte scatter in FILL; later lanes overwrite earlier ones on address collision
    always_ff @(posedge I_OMEM_HCLK or negedge I_OMEM_HRESET_N) begin
        if (!I_OMEM_HRESET_N) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'h00;
        end else if (state == S_FILL && I_OMEM_WRITE) begin
            for (int n = 0; n < 4; n++)
                if (I_OMEM_BYTE_EN[n] && lane_ok[n])
                    mem[addr[n]] <= I_OMEM_PIXEL_WDATA[8*n +: 8];
        end
    end
endmodule

// File: tb/tb_output_mem.sv
// tb_output_mem: scoreboard bench for the output tile buffer
module tb_output_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [7:0]  a0 = 8'h0, a1 = 8'h0, a2 = 8'h0, a3 = 8'h0;
    logic [31:0] pwd = 32'h0;
    logic        td = 1'b0;
    logic        wready = 1'b0;
    logic        ready, wvalid, done, err;
    logic [31:0] wdata;
    logic [5:0]  waddr;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  model [192];
    logic [31:0] seen [64];
    logic [3:0]  pat = 4'b1001;
    int          vectors = 0, miscompares = 0, hs_count = 0, done_count = 0;
    int          mode = 0, cyc = 0;

    always #5 clk = ~clk;

    output_mem dut (
        .I_OMEM_HCLK(clk),
        .I_OMEM_HRESET_N(rst_n),
        .I_OMEM_WRITE(write),
        .I_OMEM_BYTE_EN(be),
        .I_OMEM_PIXEL_IN_ADDR0(a0),
        .I_OMEM_PIXEL_IN_ADDR1(a1),
        .I_OMEM_PIXEL_IN_ADDR2(a2),
        .I_OMEM_PIXEL_IN_ADDR3(a3),
        .I_OMEM_PIXEL_WDATA(pwd),
        .I_OMEM_TILE_DONE(td),
        .O_OMEM_READY(ready),
        .O_OMEM_WDATA(wdata),
        .O_OMEM_WORD_ADDR(waddr),
        .O_OMEM_WVALID(wvalid),
        .I_OMEM_WREADY(wready),
        .O_OMEM_DONE(done),
        .O_OMEM_ERR(err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic push_tile();
        exp_t e;
        for (int w = 0; w < 48; w++) begin
            e.a = 6'(w);
            e.d = {model[4*w+3], model[4*w+2], model[4*w+1], model[4*w]};
            q.push_back(e);
        end
    endtask

    // drive one cycle; live=1 means the DUT is in FILL so the model follows
    task automatic apply(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2,
                         input logic [7:0] x3, input logic [3:0] en, input logic [31:0] d,
                         input logic wr, input logic tdone, input logic live);
        logic [7:0] ad [4];
        ad[0] = x0; ad[1] = x1; ad[2] = x2; ad[3] = x3;
        a0 = x0; a1 = x1; a2 = x2; a3 = x3;
        be = en; pwd = d; write = wr; td = tdone;
        if (live && wr)
            for (int n = 0; n < 4; n++)
                if (en[n] && ad[n] < 8'd192)
                    model[ad[n]] = d[8*n +: 8];
        if (live && tdone)
            push_tile();
        @(posedge clk); #1;
        write = 1'b0; td = 1'b0; be = 4'h0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            miscompares++;
            $display("FAIL drain_timeout: no DONE after %0d cycles", n);
        end
        check("queue_empty_at_done", 32'(q.size()), 0);
        check("ready_at_done", {31'b0, ready}, 0);
        @(posedge clk); #1;
        check("ready_after_done", {31'b0, ready}, 1);
        check("done_one_cycle", {31'b0, done}, 0);
    endtask

    // WREADY generator
    initial forever begin
        @(posedge clk); #1;
        cyc++;
        case (mode)
            0: wready = 1'b0;
            1: wready = 1'b1;
            2: wready = pat[cyc % 4];
            default: wready = (waddr != 6'd10);
        endcase
    end

    // monitor: every valid cycle is compared against the queue head; pop on handshake
    initial forever begin
        @(negedge clk);
        if (rst_n && wvalid) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: addr %0d data 0x%08h with empty scoreboard", waddr, wdata);
            end else begin
                check("word_addr", {26'b0, waddr}, {26'b0, q[0].a});
                check("wdata", wdata, q[0].d);
                check("ready_in_drain", {31'b0, ready}, 0);
                if (wready) begin
                    seen[waddr] = wdata;
                    hs_count++;
                    void'(q.pop_front());
                end
            end
        end
        if (rst_n && done)
            done_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hs0;
        for (int i = 0; i < 192; i++) model[i] = 8'h00;
        for (int i = 0; i < 64; i++) seen[i] = 32'hDEADBEEF;
        #12;
        check("rst_ready", {31'b0, ready}, 1);
        check("rst_wvalid", {31'b0, wvalid}, 0);
        check("rst_wdata", wdata, 0);
        check("rst_word_addr", {26'b0, waddr}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full tile mem[i]=i, drained with WREADY held high
        for (int c = 0; c < 48; c++)
            apply(8'(4*c), 8'(4*c+1), 8'(4*c+2), 8'(4*c+3), 4'hF,
                  {8'(4*c+3), 8'(4*c+2), 8'(4*c+1), 8'(4*c)}, 1'b1, 1'b0, 1'b1);
        mode = 1;
        apply(0, 0, 0, 0, 4'h0, 0, 1'b0, 1'b1, 1'b1);
        check("first_word_valid", {31'b0, wvalid}, 1);
        wait_done(n);
        check("drain_cycles", 32'(n), 48);
        check("word0", seen[0], 32'h03020100);
        check("word47", seen[47], 32'hBFBEBDBC);
        check("err_after_clean_tile", {31'b0, err}, 0);

        // backpressure 1,0,0,1
        mode = 2;
        hs0 = hs_count;
        apply(0, 0, 0, 0, 4'h0, 0, 1'b0, 1'b1, 1'b1);
        wait_done(n);
        check("bp_words_delivered", 32'(hs_count - hs0), 48);
        check("bp_stalls_seen", {31'b0, n > 48}, 1);

        // same-cycle write + TILE_DONE, then write/TILE_DONE during drain
        mode = 1;
        apply(188, 0, 0, 0, 4'b0001, 32'h000000AA, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("err_before_drain_write", {31'b0, err}, 0);
        apply(0, 0, 0, 0, 4'b0001, 32'h000000FF, 1'b1, 1'b1, 1'b0);
        check("err_after_drain_write", {31'b0, err}, 1);
        wait_done(n);
        check("word47_same_cycle", seen[47], 32'hBFBEBDAA);
        apply(0, 0, 0, 0, 4'h0, 0, 1'b0, 1'b1, 1'b1);
        wait_done(n);
        check("word0_unchanged", seen[0], 32'h03020100);
        check("err_sticky", {31'b0, err}, 1);

        // reset during the word 10 stall
        mode = 3;
        apply(0, 0, 0, 0, 4'h0, 0, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (!(wvalid && waddr == 6'd10) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_word10", {26'b0, waddr}, 10);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_wvalid", {31'b0, wvalid}, 0);
        check("abort_ready", {31'b0, ready}, 1);
        check("abort_wdata", wdata, 0);
        check("abort_word_addr", {26'b0, waddr}, 0);
        check("abort_err", {31'b0, err}, 0);
        q.delete();
        for (int i = 0; i < 192; i++) model[i] = 8'h00;
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mode = 1;
        apply(0, 0, 0, 0, 4'h0, 0, 1'b0, 1'b1, 1'b1);
        wait_done(n);
        check("post_reset_word0", seen[0], 32'h0);
        check("post_reset_word10", seen[10], 32'h0);
        check("post_reset_word47", seen[47], 32'h0);

        // lane conflict and out-of-range lane
        apply(5, 0, 5, 0, 4'b0101, 32'h44332211, 1'b1, 1'b0, 1'b1);
        check("err_after_conflict", {31'b0, err}, 0);
        apply(6, 200, 0, 0, 4'b0011, 32'h000077EE, 1'b1, 1'b0, 1'b1);
        check("err_after_oob", {31'b0, err}, 1);
        apply(0, 0, 0, 0, 4'h0, 0, 1'b0, 1'b1, 1'b1);
        wait_done(n);
        check("word1_conflict", seen[1], 32'h00EE3300);
        check("done_pulses", 32'(done_count), 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
